// File: rtl/aes_pkg.sv
// Shared AES types, S-box and byte-level round primitives for the iterative engine.
// Every state_t element is a byte. s[c][r] is column c, row r, and s[0][0] is the most significant byte.
package aes_pkg;

    typedef logic [0:3][0:3][7:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic int nr_of(input int key_width);
        case (key_width)
            192:     return 12;
            256:     return 14;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[c][rw] = SBOX[s[c][rw]];
            end
        end
        return r;
    endfunction

    // Row rw rotates left by rw columns.
    function automatic state_t shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[c][rw] = s[(c + rw) % 4][rw];
            end
        end
        return r;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c][0];
            a1 = s[c][1];
            a2 = s[c][2];
            a3 = s[c][3];
            r[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_fn.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_fn
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] state_out
);

    state_t       s_in;
    state_t       s_shifted;
    state_t       s_mixed;
    logic [127:0] pre_key;

    always_comb begin
        s_in      = state_t'(state_in);
        s_shifted = shift_rows(sub_bytes(s_in));
        s_mixed   = mix_columns(s_shifted);
        // The last round of the cipher omits MixColumns.
        pre_key   = final_round ? 128'(s_shifted) : 128'(s_mixed);
        state_out = pre_key ^ round_key;
    end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryptor. It runs the initial AddRoundKey and then Nr rounds, one per clock.
// Round keys are fetched by index from an external key store that answers in the same cycle.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 128,
    parameter int RK_IDX_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [RK_IDX_W-1:0]   rk_idx,
    input  logic [127:0]          round_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    input  logic                  flush
);

    localparam int                   NR     = nr_of(KEY_WIDTH);
    localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

    if (DATA_WIDTH != 128) begin : g_bad_data_width
        $error("aes_round_engine: DATA_WIDTH must be 128");
    end
    if (KEY_WIDTH != 128 && KEY_WIDTH != 192 && KEY_WIDTH != 256) begin : g_bad_key_width
        $error("aes_round_engine: KEY_WIDTH must be 128, 192 or 256");
    end
    if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_width
        $error("aes_round_engine: RK_IDX_W too narrow for Nr");
    end

    fsm_e                  fsm_reg;
    logic [DATA_WIDTH-1:0] state_reg;
    logic [RK_IDX_W-1:0]   rnd_reg;
    logic                  out_valid_reg;
    logic                  busy_reg;
    logic [127:0]          round_out;
    logic                  final_round;
    logic                  accept;

    // rnd_reg is held at 0 outside ROUND, so IDLE and DONE both request round key 0.
    // That lets a block accepted in DONE do its initial AddRoundKey without a bubble.
    assign rk_idx      = rnd_reg;
    assign final_round = (rnd_reg == NR_IDX);
    assign in_ready    = !flush && ((fsm_reg == ST_IDLE) ||
                                    (fsm_reg == ST_DONE && out_ready));
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_reg;
    assign out_data    = state_reg;
    assign busy        = busy_reg;

    aes_round_fn u_round_fn (
        .state_in    (state_reg),
        .round_key   (round_key),
        .final_round (final_round),
        .state_out   (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg       <= ST_IDLE;
            state_reg     <= '0;
            rnd_reg       <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (flush) begin
            fsm_reg       <= ST_IDLE;
            state_reg     <= '0;
            rnd_reg       <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (fsm_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= in_data ^ round_key;
                        rnd_reg   <= RK_IDX_W'(1);
                        busy_reg  <= 1'b1;
                        fsm_reg   <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (rnd_reg == '0 || rnd_reg > NR_IDX) begin
                        fsm_reg  <= ST_IDLE;
                        rnd_reg  <= '0;
                        busy_reg <= 1'b0;
                    end else begin
                        state_reg <= round_out;
                        if (final_round) begin
                            rnd_reg       <= '0;
                            out_valid_reg <= 1'b1;
                            fsm_reg       <= ST_DONE;
                        end else begin
                            rnd_reg <= rnd_reg + RK_IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (accept) begin
                            state_reg <= in_data ^ round_key;
                            rnd_reg   <= RK_IDX_W'(1);
                            fsm_reg   <= ST_ROUND;
                        end else begin
                            busy_reg <= 1'b0;
                            fsm_reg  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    fsm_reg       <= ST_IDLE;
                    rnd_reg       <= '0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES encryption datapath, parametrised for 128/192/256-bit keys (Nr = 10/12/14).
- Takes one plaintext block per valid/ready handshake and applies AddRoundKey(0) followed by Nr rounds, one per cycle.
- Delivers the ciphertext on a valid/ready output.
- Fetches round keys by index from an external key-schedule store, and owns the round FSM plus the mux/enable sequencing the previous rounds block needed from outside.

Parameters:
- DATA_WIDTH, 128, block width; only 128 legal (elaboration assertion otherwise).
- KEY_WIDTH, 128, cipher key size; one of 128/192/256, selects Nr = 10/12/14.
- RK_IDX_W, 4, width of round-key index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  engine can accept plaintext.
- in_data  in  DATA_WIDTH  plaintext block.
- rk_idx  out  RK_IDX_W  round-key index requested this cycle.
- round_key  in  128  round key for rk_idx, combinational same cycle.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  DATA_WIDTH  ciphertext.
- busy  out  1  block in flight (ROUND or DONE).
- flush  in  1  synchronous abort of in-flight block.

Behaviour:
- Reset and interface: clk is the only clock; rst is synchronous and active-high.
- Reset values: state = IDLE, round counter = 0, state register = 0, in_ready = 1, out_valid = 0, out_data = 0, busy = 0, rk_idx = 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - rk_idx = 0.
  - On in_valid & in_ready: state_reg <= in_data ^ round_key; rnd <= 1; go to ROUND.
- ROUND:
  - rk_idx = rnd.
  - state_reg <= round_fn(state_reg, round_key, final = (rnd == Nr)).
  - Non-final round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Final round: MixColumns skipped.
  - rnd increments; after the rnd == Nr cycle, go to DONE.
- DONE:
  - out_valid = 1; out_data = state_reg, held stable until out_ready.
  - On out_ready: go to IDLE.
  - If in_valid is also high in that same cycle, accept the new block directly: load in_data ^ round_key and go to ROUND. rk_idx = 0 in DONE makes this possible.
- in_ready = (state == IDLE) | (state == DONE & out_ready). in_ready is never combinationally dependent on in_valid.
- Latency: with acceptance in cycle 0, out_valid is first high in cycle Nr+1 (11/13/15 cycles).
- Throughput: one block per Nr+1 cycles with out_ready held high.
- flush:
  - Highest priority after rst.
  - Forces IDLE, out_valid = 0, rnd = 0.
  - An in_valid in the same cycle is not accepted, because in_ready is forced to 0 while flush is high.
- Backpressure: DONE holds indefinitely; no data loss; rk_idx stays stable.
- Round counter: never exceeds Nr; an out-of-range rnd is unreachable and routes to IDLE.
- rst mid-operation: block is discarded; all outputs return to reset values on the next edge.

Decomposition:
- aes_pkg holds:
  - the state_t typedef (4x4 byte array);
  - the SBOX constant;
  - functions xtime, sub_bytes, shift_rows, mix_columns;
  - the function nr_of(KEY_WIDTH);
  - the fsm_e enum.
- One combinational sub-module, aes_round_fn, with ports (state_in, round_key, final_round, state_out). The engine instantiates it once.

Test Plan:
- AES-128, FIPS-197 C.1: key 000102..0f with the bench model serving round keys, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid first high 11 cycles after acceptance.
- KEY_WIDTH=192, C.2: key 00..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 at cycle 13. KEY_WIDTH=256, C.3: key 00..1f -> 8ea2b7ca516745bfeafc49904b496089 at cycle 15.
- Back-to-back: two blocks with out_ready=1 and in_valid held -> second accepted in the DONE cycle of the first; outputs spaced exactly 11 cycles; both ciphertexts correct.
- Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0; release -> single handshake, return to IDLE.
- flush asserted at round 5 -> next cycle IDLE, out_valid never asserts for that block; a new C.1 block then completes correctly.
- rst asserted in ROUND and in DONE -> next cycle in_ready=1, out_valid=0, out_data=0, rk_idx=0.
